// File: rtl/demux_4op.sv
// demux_4op: 1-to-4 serial demultiplexer with addressed and auto-scan routing
module demux_4op #(
    parameter bit CLEAR_ON_DISABLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       mode,
    input  logic       data_ip,
    input  logic       valid_ip,
    input  logic [1:0] control_ip,
    output logic [3:0] demux_op,
    output logic [3:0] op_valid,
    output logic       frame_done,
    output logic [1:0] scan_cnt,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, ADDR, SCAN} state_t;
    state_t state, state_nxt;
    logic       accept;
    logic [1:0] ch;
    logic [3:0] op_nxt, vld_nxt;
    logic       fd_nxt;
    logic [1:0] cnt_nxt;
    assign accept = valid_ip & en & (state != IDLE);
    assign ch     = (state == SCAN) ? scan_cnt : control_ip;
    assign busy   = (state == SCAN) && (scan_cnt != 2'd0);
    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    // disable wins; otherwise mode alone selects the routing state
    always_comb state_nxt = !en ? IDLE : (mode ? SCAN : ADDR);
    // next output values: accept is served under the current state before any transition
    always_comb begin
        op_nxt  = demux_op;
        vld_nxt = 4'b0000;
        fd_nxt  = 1'b0;
        if (accept) begin
            op_nxt[ch] = data_ip;
            vld_nxt    = 4'b0001 << ch;
            fd_nxt     = (state == SCAN) && (scan_cnt == 2'd3);
        end
        if (state_nxt == IDLE && CLEAR_ON_DISABLE) op_nxt = 4'b0000;
        cnt_nxt = (state == SCAN && state_nxt == SCAN) ? scan_cnt + {1'b0, accept} : 2'd0;
    end
    // output registers
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            demux_op   <= 4'b0000;
            op_valid   <= 4'b0000;
            frame_done <= 1'b0;
            scan_cnt   <= 2'd0;
        end else begin
            demux_op   <= op_nxt;
            op_valid   <= vld_nxt;
            frame_done <= fd_nxt;
            scan_cnt   <= cnt_nxt;
        end
endmodule

// File: tb/tb_demux_4op.sv
// tb_demux_4op: table-driven, directed and randomized checks of demux_4op against a frame-level model
module tb_demux_4op;
    logic       clk = 1'b0, rst = 1'b1;
    logic       en = 1'b0, mode = 1'b0, data_ip = 1'b0, valid_ip = 1'b0;
    logic [1:0] control_ip = 2'd0;
    logic [3:0] op0, vld0, op1, vld1;
    logic       fd0, fd1, busy0, busy1;
    logic [1:0] cnt0, cnt1;
    int checks = 0, errors = 0;

    demux_4op #(.CLEAR_ON_DISABLE(1'b1)) u0 (.clk(clk), .rst(rst), .en(en), .mode(mode), .data_ip(data_ip),
        .valid_ip(valid_ip), .control_ip(control_ip), .demux_op(op0), .op_valid(vld0), .frame_done(fd0),
        .scan_cnt(cnt0), .busy(busy0));
    demux_4op #(.CLEAR_ON_DISABLE(1'b0)) u1 (.clk(clk), .rst(rst), .en(en), .mode(mode), .data_ip(data_ip),
        .valid_ip(valid_ip), .control_ip(control_ip), .demux_op(op1), .op_valid(vld1), .frame_done(fd1),
        .scan_cnt(cnt1), .busy(busy1));

    always #5 clk = ~clk;

    // model: 0 = idle, 1 = addressed, 2 = scan; the partial scan frame is a queue of collected bits
    int         ms = 0;
    logic [3:0] mop0 = 4'b0, mop1 = 4'b0, mvld = 4'b0;
    logic       mfd = 1'b0;
    bit         mq[$];

    task automatic model_reset();
        ms = 0; mop0 = 4'b0; mop1 = 4'b0; mvld = 4'b0; mfd = 1'b0; mq.delete();
    endtask

    task automatic model_step(input bit e, input bit md, input bit d, input bit v, input bit [1:0] c);
        int nxt;
        logic [1:0] ch;
        nxt = !e ? 0 : (md ? 2 : 1);
        mvld = 4'b0; mfd = 1'b0;
        if (v && e && ms != 0) begin
            ch = (ms == 1) ? c : 2'(mq.size());
            mop0[ch] = d; mop1[ch] = d; mvld[ch] = 1'b1;
            if (ms == 2) begin
                mq.push_back(d);
                if (mq.size() == 4) begin mfd = 1'b1; mq.delete(); end
            end
        end
        if (nxt != 2) mq.delete();
        if (nxt == 0) mop0 = 4'b0;
        ms = nxt;
    endtask

    task automatic expect_eq(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk(input string nm);
        logic mb;
        mb = (ms == 2) && (mq.size() != 0);
        expect_eq({nm, ".op"}, op0, mop0);
        expect_eq({nm, ".vld"}, vld0, mvld);
        expect_eq({nm, ".fd"}, {3'b0, fd0}, {3'b0, mfd});
        expect_eq({nm, ".cnt"}, {2'b0, cnt0}, 4'(mq.size()));
        expect_eq({nm, ".busy"}, {3'b0, busy0}, {3'b0, mb});
        expect_eq({nm, ".hold_op"}, op1, mop1);
        expect_eq({nm, ".hold_vld"}, vld1, mvld);
        expect_eq({nm, ".hold_fd"}, {3'b0, fd1}, {3'b0, mfd});
        expect_eq({nm, ".hold_cnt"}, {2'b0, cnt1}, 4'(mq.size()));
        expect_eq({nm, ".hold_busy"}, {3'b0, busy1}, {3'b0, mb});
    endtask

    task automatic tick(input string nm);
        @(posedge clk);
        model_step(en, mode, data_ip, valid_ip, control_ip);
        #1;
        chk(nm);
    endtask

    task automatic apply(input bit e, input bit md, input bit d, input bit v, input bit [1:0] c, input string nm);
        en = e; mode = md; data_ip = d; valid_ip = v; control_ip = c;
        tick(nm);
    endtask

    typedef struct {
        bit e, md, d, v;
        bit [1:0] c;
        bit [3:0] op, vld;
        bit fd;
        bit [1:0] cnt;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0, 2'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0100, 4'b0100, 1'b0, 2'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0100, 4'b0000, 1'b0, 2'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0100, 4'b0000, 1'b0, 2'd0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0101, 4'b0001, 1'b0, 2'd1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0101, 4'b0010, 1'b0, 2'd2};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0101, 4'b0100, 1'b0, 2'd3};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 4'b1101, 4'b1000, 1'b1, 2'd0};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'b1101, 4'b0000, 1'b0, 2'd0};
        tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0, 2'd0};
        model_reset();
        #3 chk("reset");
        #9 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            apply(tbl[i].e, tbl[i].md, tbl[i].d, tbl[i].v, tbl[i].c, $sformatf("vec%0d", i));
            expect_eq($sformatf("tbl%0d.op", i), op0, tbl[i].op);
            expect_eq($sformatf("tbl%0d.vld", i), vld0, tbl[i].vld);
            expect_eq($sformatf("tbl%0d.fd", i), {3'b0, fd0}, {3'b0, tbl[i].fd});
            expect_eq($sformatf("tbl%0d.cnt", i), {2'b0, cnt0}, {2'b0, tbl[i].cnt});
        end
        // mode switch mid-frame discards the partial frame
        apply(1, 1, 0, 0, 0, "ms_enter");
        apply(1, 1, 1, 1, 0, "ms_a0");
        apply(1, 1, 1, 1, 0, "ms_a1");
        apply(1, 0, 0, 0, 0, "ms_switch");
        expect_eq("ms.cnt", {2'b0, cnt0}, 4'd0);
        expect_eq("ms.busy", {3'b0, busy0}, 4'd0);
        expect_eq("ms.fd", {3'b0, fd0}, 4'd0);
        apply(1, 0, 1, 1, 3, "ms_addr3");
        expect_eq("ms.addr3_op", op0, 4'b1011);
        expect_eq("ms.addr3_vld", vld0, 4'b1000);
        // disable after writing all ones: clear vs hold, valid ignored
        for (int i = 0; i < 4; i++) apply(1, 0, 1, 1, 2'(i), "fill");
        apply(0, 0, 0, 1, 0, "dis");
        expect_eq("dis.clear_op", op0, 4'b0000);
        expect_eq("dis.hold_op", op1, 4'b1111);
        expect_eq("dis.vld", vld1, 4'b0000);
        // last scan slot accepted in the same cycle mode drops still completes the frame
        apply(1, 1, 0, 0, 0, "fd_enter");
        for (int i = 0; i < 3; i++) apply(1, 1, 1, 1, 0, "fd_fill");
        apply(1, 0, 0, 1, 0, "fd_last");
        expect_eq("fd_switch.fd", {3'b0, fd0}, 4'd1);
        expect_eq("fd_switch.cnt", {2'b0, cnt0}, 4'd0);
        apply(1, 0, 0, 0, 0, "fd_after");
        expect_eq("fd_after.fd", {3'b0, fd0}, 4'd0);
        // asynchronous reset between edges at scan_cnt=2
        apply(0, 0, 0, 0, 0, "ar_idle");
        apply(1, 1, 0, 0, 0, "ar_enter");
        apply(1, 1, 1, 1, 0, "ar_a0");
        apply(1, 1, 1, 1, 0, "ar_a1");
        expect_eq("ar.cnt_before", {2'b0, cnt0}, 4'd2);
        #2 rst = 1'b1;
        model_reset();
        #1 chk("areset");
        expect_eq("ar.op", op1, 4'b0000);
        expect_eq("ar.cnt", {2'b0, cnt0}, 4'd0);
        #1 rst = 1'b0;
        apply(1, 1, 1, 1, 0, "ar_rel0");
        expect_eq("ar_rel0.vld", vld0, 4'b0000);
        apply(1, 1, 1, 1, 0, "ar_rel1");
        apply(1, 1, 1, 1, 0, "ar_rel2");
        expect_eq("ar_rel2.fd", {3'b0, fd0}, 4'd0);
        // re-enable with valid held: first edge never writes
        apply(0, 0, 0, 0, 0, "re_idle");
        apply(1, 0, 1, 1, 0, "re_first");
        expect_eq("re_first.vld", vld0, 4'b0000);
        apply(1, 0, 1, 1, 0, "re_second");
        expect_eq("re_second.vld", vld0, 4'b0001);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            en = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            valid_ip = ($urandom_range(0, 3) != 0);
            data_ip = 1'($urandom);
            control_ip = 2'($urandom);
            tick("rand");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
